// File: rtl/myperiph_gpio.sv
// -----------------------------------------------------------------------------
// myperiph_gpio
//
// Small GPIO peripheral: N_CH debounced push-buttons, N_CH LEDs with optional
// blink, a word-addressed CSR block and a level interrupt on button press.
//
// Register map (word address, bits [N_CH-1:0] only, upper bits read 0):
//   0x0 LED_OUT   RW  software LED value
//   0x1 LED_MODE  RW  1 = LED follows debounced button, 0 = LED_OUT
//   0x2 BTN_STATE RO  debounced button state
//   0x3 EVENT     W1C sticky debounced rising-edge flags
//   0x4 IRQ_EN    RW  per-channel interrupt enable
//   0x5 BLINK_EN  RW  per-channel blink gating
//   others        read 0, writes ignored
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   csr_addr   in   [3:0]  register word address
//   csr_wdata  in   [31:0] write data
//   csr_we     in   write strobe, one write per asserted cycle
//   csr_rdata  out  [31:0] registered read data (addr sampled last cycle)
//   buttons    in   [N_CH-1:0] asynchronous raw button levels, active-high
//   leds       out  [N_CH-1:0] registered LED drive, active-high
//   irq        out  registered level interrupt
// -----------------------------------------------------------------------------
module myperiph_gpio #(
   parameter int N_CH            = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int BLINK_DIV_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        csr_addr,
   input  logic [31:0]       csr_wdata,
   input  logic              csr_we,
   output logic [31:0]       csr_rdata,
   input  logic [N_CH-1:0]   buttons,
   output logic [N_CH-1:0]   leds,
   output logic              irq
);

   localparam int              CNT_W   = 16;
   localparam logic [CNT_W-1:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

   localparam logic [3:0] A_LED_OUT  = 4'h0;
   localparam logic [3:0] A_LED_MODE = 4'h1;
   localparam logic [3:0] A_BTN      = 4'h2;
   localparam logic [3:0] A_EVENT    = 4'h3;
   localparam logic [3:0] A_IRQ_EN   = 4'h4;
   localparam logic [3:0] A_BLINK_EN = 4'h5;

   // Zero-extend a channel-wide register to the 32-bit bus; written this way
   // so N_CH=32 needs no zero-width replication.
   function automatic logic [31:0] f_zext(input logic [N_CH-1:0] v);
      logic [31:0] r;
      r         = '0;
      r[N_CH-1:0] = v;
      return r;
   endfunction

   // Synchroniser / debounce state
   logic [N_CH-1:0]  r_sync_p0;
   logic [N_CH-1:0]  r_sync_p1;
   logic [CNT_W-1:0] r_db_cnt [N_CH];
   logic [N_CH-1:0]  r_db;

   // CSR state
   logic [N_CH-1:0]  r_led_out;
   logic [N_CH-1:0]  r_led_mode;
   logic [N_CH-1:0]  r_event;
   logic [N_CH-1:0]  r_irq_en;
   logic [N_CH-1:0]  r_blink_en;

   // Blink generator
   logic [BLINK_DIV_W-1:0] r_blink_cnt;
   logic                   r_phase;

   // Registered outputs
   logic [N_CH-1:0]  r_leds;
   logic             r_irq;
   logic [31:0]      r_rdata;

   logic [N_CH-1:0]  w_db_next;
   logic [CNT_W-1:0] w_cnt_next [N_CH];
   logic [N_CH-1:0]  w_db_rise;
   logic [N_CH-1:0]  w_wdata;
   logic [N_CH-1:0]  w_w1c;
   logic [N_CH-1:0]  w_src;
   logic [N_CH-1:0]  w_led_drive;
   logic [31:0]      w_rd_mux;
   logic             w_unused_wdata;

   // Upper write-data bits are architecturally ignored.
   assign w_unused_wdata = ^csr_wdata;
   assign w_wdata        = csr_wdata[N_CH-1:0];

   // Debounce: count while the synchronised level disagrees with the accepted
   // state; the flip happens on the edge where the count already sits at
   // DEBOUNCE_CYCLES-1, so a change needs exactly DEBOUNCE_CYCLES edges.
   always_comb begin
      w_db_next = r_db;
      for (int i = 0; i < N_CH; i++) begin
         w_cnt_next[i] = '0;
         if (r_sync_p1[i] != r_db[i]) begin
            if (r_db_cnt[i] == DB_LAST) begin
               w_db_next[i] = ~r_db[i];
            end else begin
               w_cnt_next[i] = r_db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_db_rise = w_db_next & ~r_db;

   // A rising edge set wins over a simultaneous W1C of the same bit.
   assign w_w1c = (csr_we && (csr_addr == A_EVENT)) ? w_wdata : '0;

   assign w_src       = (r_led_mode & r_db) | (~r_led_mode & r_led_out);
   assign w_led_drive = w_src & ({N_CH{r_phase}} | ~r_blink_en);

   // Read mux uses current register values, so a same-cycle write is not
   // visible until the following read.
   always_comb begin
      w_rd_mux = '0;
      case (csr_addr)
         A_LED_OUT:  w_rd_mux = f_zext(r_led_out);
         A_LED_MODE: w_rd_mux = f_zext(r_led_mode);
         A_BTN:      w_rd_mux = f_zext(r_db);
         A_EVENT:    w_rd_mux = f_zext(r_event);
         A_IRQ_EN:   w_rd_mux = f_zext(r_irq_en);
         A_BLINK_EN: w_rd_mux = f_zext(r_blink_en);
         default:    w_rd_mux = '0;
      endcase
   end

   // --- stage: input synchroniser and debounce ---
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync_p0 <= '0;
         r_sync_p1 <= '0;
         r_db      <= '0;
         for (int i = 0; i < N_CH; i++) begin
            r_db_cnt[i] <= '0;
         end
      end else begin
         r_sync_p0 <= buttons;
         r_sync_p1 <= r_sync_p0;
         r_db      <= w_db_next;
         for (int i = 0; i < N_CH; i++) begin
            r_db_cnt[i] <= w_cnt_next[i];
         end
      end
   end

   // --- stage: CSR registers and event capture ---
   always_ff @(posedge clk) begin
      if (rst) begin
         r_led_out  <= '0;
         r_led_mode <= '0;
         r_irq_en   <= '0;
         r_blink_en <= '0;
         r_event    <= '0;
      end else begin
         if (csr_we) begin
            case (csr_addr)
               A_LED_OUT:  r_led_out  <= w_wdata;
               A_LED_MODE: r_led_mode <= w_wdata;
               A_IRQ_EN:   r_irq_en   <= w_wdata;
               A_BLINK_EN: r_blink_en <= w_wdata;
               default:    ;
            endcase
         end
         r_event <= (r_event & ~w_w1c) | w_db_rise;
      end
   end

   // --- stage: blink phase generator ---
   always_ff @(posedge clk) begin
      if (rst) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b1;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
         if (&r_blink_cnt) begin
            r_phase <= ~r_phase;
         end
      end
   end

   // --- stage: registered outputs ---
   always_ff @(posedge clk) begin
      if (rst) begin
         r_leds  <= '0;
         r_irq   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_leds  <= w_led_drive;
         r_irq   <= |(r_event & r_irq_en);
         r_rdata <= w_rd_mux;
      end
   end

   assign leds      = r_leds;
   assign irq       = r_irq;
   assign csr_rdata = r_rdata;

endmodule
